cnt_timeout_ctrl: RTL

//  Control FSM that drives the hardened up/down counter's control port as a

---
 rtl/cnt_timeout_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cnt_timeout_ctrl.sv
// cnt_timeout_ctrl: drives an attached up/down counter as a reloadable
// down-counting timeout. Counter controls are decoded combinationally from
// the FSM state and the request inputs; status outputs follow the state.
// A counter integrity error or a corrupted state register escalates to a
// terminal ERROR state that only rst_ni can leave.
module cnt_timeout_ctrl #(
    parameter int Width    = 16,
    parameter bit ErrCheck = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             kick_i,
    input  logic             stop_i,
    input  logic [Width-1:0] timeout_i,
    input  logic [Width-1:0] cnt_i,
    input  logic             cnt_err_i,
    output logic             cnt_clr_o,
    output logic             cnt_set_o,
    output logic [Width-1:0] cnt_set_val_o,
    output logic             cnt_incr_o,
    output logic             cnt_decr_o,
    output logic [Width-1:0] cnt_step_o,
    output logic             cnt_commit_o,
    output logic             busy_o,
    output logic             expired_o,
    output logic             expire_pulse_o,
    output logic             err_o
);

    // Sparse encoding: every pair of legal states differs in at least three
    // bits, so a single or double bit upset can never land on another legal
    // state and is always caught by the default branch.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00000,
        ST_RUN     = 5'b00111,
        ST_EXPIRED = 5'b11001,
        ST_ERROR   = 5'b11110
    } state_e;

    logic [4:0] r_state;
    state_e     w_state_next;
    logic       r_expire_pulse;
    logic       w_clr;
    logic       w_set;
    logic       w_decr;
    logic       w_cnt_zero;
    logic       w_cnt_err;

    assign w_cnt_zero = (cnt_i == '0);
    assign w_cnt_err  = ErrCheck ? cnt_err_i : 1'b0;

    // Next-state and counter-control decode; stop beats reload beats counting.
    always_comb begin
        w_state_next = state_e'(r_state);
        w_clr        = 1'b0;
        w_set        = 1'b0;
        w_decr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (stop_i) begin
                    w_clr = 1'b1;
                end else if (start_i) begin
                    w_set        = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_clr        = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (start_i || kick_i) begin
                    // A reload in the cycle the count reaches zero beats expiry.
                    w_set = 1'b1;
                end else if (w_cnt_zero) begin
                    // No decrement at zero: the counter is left holding.
                    w_state_next = ST_EXPIRED;
                end else begin
                    w_decr = 1'b1;
                end
            end
            ST_EXPIRED: begin
                if (stop_i) begin
                    w_clr        = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (start_i) begin
                    w_set        = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_ERROR: begin
                w_state_next = ST_ERROR;
            end
            default: begin
                w_state_next = ST_ERROR;
            end
        endcase
        // A faulty counter must not be committed to; go straight to ERROR.
        if (w_cnt_err) begin
            w_state_next = ST_ERROR;
            w_clr        = 1'b0;
            w_set        = 1'b0;
            w_decr       = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One-cycle pulse registered on the transition into EXPIRED.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_expire_pulse <= 1'b0;
        end else begin
            r_expire_pulse <= (w_state_next == ST_EXPIRED) && (r_state != ST_EXPIRED);
        end
    end

    assign cnt_clr_o      = w_clr;
    assign cnt_set_o      = w_set;
    assign cnt_decr_o     = w_decr;
    assign cnt_incr_o     = 1'b0;
    assign cnt_set_val_o  = timeout_i;
    assign cnt_step_o     = Width'(1);
    assign cnt_commit_o   = w_clr | w_set | w_decr;

    assign busy_o         = (r_state == ST_RUN);
    assign expired_o      = (r_state == ST_EXPIRED);
    assign expire_pulse_o = r_expire_pulse;
    assign err_o          = (r_state == ST_ERROR);

endmodule
